stream_unpacker: RTL
====================

# stream_unpacker

Width-down converter on the valid/ready stream interface: accepts one wide word of RATIO lanes per transfer and emits its lanes one DATA_W beat at a time, least-significant lane first. It sits on the read side of the team's FIFOs, draining wide buffered words into narrow byte-stream consumers. It supports partial words and runs at full throughput with no bubble between words.

## Interface
- DATA_W, 8, width of one output beat (lane)
- RATIO, 4, lanes per input word; power of two, ≥ 2
- IDX_W, $clog2(RATIO), derived; width of lane index and count fields
- clk  input  1  clock; all state updates on rising edge
- nrst  input  1  reset; asynchronous assert, active-low
- a_data  input  DATA_W*RATIO  input word; lane k = a_data[k*DATA_W +: DATA_W]
- a_nbeats_m1  input  IDX_W  number of valid lanes minus 1 (0 → lane 0 only)
- a_valid  input  1  input word valid
- a_ready  output  1  block accepts a word this cycle
- b_data  output  DATA_W  current output lane
- b_valid  output  1  output beat valid
- b_ready  input  1  consumer accepts beat
- b_last  output  1  current beat is the final lane of its word

## Operation
- State: busy flag, hold register (DATA_W*RATIO), lane index idx (IDX_W), end index last_idx (IDX_W).
- Two states: IDLE (busy=0) and DRAIN (busy=1).
- Transfer on a side: a_valid & a_ready at a rising edge. Transfer on b side: b_valid & b_ready.
- a_ready = nrst & (~busy | (b_valid & b_ready & b_last)); combinational path b_ready → a_ready is intentional.
- b_valid = busy; b_data = hold lane idx; b_last = busy & (idx == last_idx).
- IDLE, a transfer: hold ← a_data, last_idx ← a_nbeats_m1, idx ← 0, busy ← 1.
- DRAIN, b transfer, not last: idx ← idx + 1.
- DRAIN, b transfer on last beat, no a transfer: busy ← 0 (→ IDLE); idx ← 0.
- DRAIN, b transfer on last beat with simultaneous a transfer: reload hold/last_idx, idx ← 0, stay DRAIN.
- DRAIN, no b transfer: all state held; b_data/b_last stable while b_valid & ~b_ready.
- Lanes above a_nbeats_m1 are discarded, never emitted.
- a_data/a_nbeats_m1 ignored when no a transfer; b_ready ignored when b_valid=0.
- idx never exceeds last_idx; no wrap-around occurs within a word.

## Timing
- Reset (nrst low, asynchronous): busy=0, idx=0, last_idx=0, hold=0. Outputs during/after reset: b_valid=0, b_last=0, b_data=0, a_ready=0 while nrst low, a_ready=1 from first cycle after release.
- Reset mid-word: in-flight word dropped immediately; b_valid falls asynchronously with nrst.
- Latency: word accepted at edge N → its lane 0 valid in cycle after edge N.
- Throughput: word of n lanes occupies exactly n cycles with b_ready held high; next word's lane 0 follows the previous last beat with zero idle cycles.
- Single-lane words (a_nbeats_m1=0) sustain one word per cycle.
- Backpressure: b_ready low stalls with no state change; a_ready stays 0 throughout DRAIN except on the last-beat transfer cycle.

## Test plan
- Reset release, a_valid=0: a_ready=1, b_valid=0, b_last=0, b_data=0 on first post-reset cycle.
- a_data=0x44332211, a_nbeats_m1=3, b_ready=1 constant → beats 0x11,0x22,0x33,0x44 on 4 consecutive cycles, b_last only with 0x44; a_ready=1 only on 0x44 cycle.
- Back-to-back words 0x44332211 (m1=3) then 0xDDCCBBAA (m1=1), a_valid held → 0x11,0x22,0x33,0x44,0xAA,0xBB with no gap; b_last on 0x44 and 0xBB; 0xCC/0xDD never appear.
- Same 0x44332211 word with b_ready toggled 1,0,0,1,1,0,1 → b_data holds 0x22 through the stall cycles; sequence order unchanged; a_ready never 1 during stalls.
- Four single-lane words 0x..01..0x..04 (m1=0), b_ready=1 → one beat per cycle, b_last=1 every beat, a_ready=1 every cycle.
- Word 0x44332211 accepted, nrst pulsed low after beat 0x22 → b_valid=0 immediately; after release new word 0x000000EE (m1=0) yields single beat 0xEE with b_last=1; 0x33/0x44 never emitted.

Source files
------------

// File: rtl/stream_unpacker.sv
// stream_unpacker: width-down stream converter, one wide word in,
// its valid lanes out one beat at a time, least-significant lane first.
module stream_unpacker #(
    parameter int DATA_W = 8,
    parameter int RATIO  = 4,
    parameter int IDX_W  = $clog2(RATIO)
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [DATA_W*RATIO-1:0]   a_data,
    input  logic [IDX_W-1:0]          a_nbeats_m1,
    input  logic                      a_valid,
    output logic                      a_ready,
    output logic [DATA_W-1:0]         b_data,
    output logic                      b_valid,
    input  logic                      b_ready,
    output logic                      b_last
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [RATIO-1:0][DATA_W-1:0] hold;
    logic [IDX_W-1:0]             idx;
    logic [IDX_W-1:0]             last_idx;

    logic busy;
    logic a_fire;
    logic b_fire;
    logic at_last;

    assign busy    = (state == DRAIN);
    assign at_last = busy & (idx == last_idx);
    assign b_fire  = busy & b_ready;
    // Last-beat handoff lets the next word load with no idle cycle between words.
    assign a_ready = nrst & (~busy | (b_fire & at_last));
    assign a_fire  = a_valid & a_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (a_fire) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (b_fire && at_last && !a_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hold     <= '0;
            idx      <= '0;
            last_idx <= '0;
        end else if (a_fire) begin
            hold     <= a_data;
            last_idx <= a_nbeats_m1;
            idx      <= '0;
        end else if (b_fire && at_last) begin
            idx <= '0;
        end else if (b_fire) begin
            idx <= idx + 1'b1;
        end
    end

    always_comb begin
        b_valid = busy;
        b_last  = at_last;
        b_data  = hold[idx];
    end

endmodule
